// File: rtl/rfm_tracker_mb.sv
// Multi-bank RFM tracker: per-bank Misra-Gries row table with spillover counter,
// rolling accumulated ACT (RAA) counters with alerts, and NRR issue on RFM.
module rfm_tracker_mb #(
    parameter int unsigned NUM_BANK   = 4,
    parameter int unsigned BANK_BITS  = 2,
    parameter int unsigned NUM_ENTRY  = 16,
    parameter int unsigned ENTRY_BITS = 4,
    parameter int unsigned ADDR_SIZE  = 18,
    parameter int unsigned CNT_SIZE   = 16,
    parameter int unsigned RFM_TH     = 20,
    parameter int unsigned RAA_IMT    = 32,
    parameter int unsigned RAA_MAX    = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_type,
    input  logic [BANK_BITS-1:0] cmd_bank,
    input  logic [ADDR_SIZE-1:0] cmd_addr,
    output logic                 nrr_valid,
    output logic [BANK_BITS-1:0] nrr_bank,
    output logic [ADDR_SIZE-1:0] nrr_addr,
    output logic [NUM_BANK-1:0]  alert
);

    typedef enum logic [2:0] {StIdle, StLookup, StUpdate, StScan, StEmit} state_e;

    localparam logic [CNT_SIZE-1:0] RfmTh  = CNT_SIZE'(RFM_TH);
    localparam logic [CNT_SIZE-1:0] RaaImt = CNT_SIZE'(RAA_IMT);
    localparam logic [CNT_SIZE-1:0] RaaMax = CNT_SIZE'(RAA_MAX);

    function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
        return (v == '1) ? v : v + CNT_SIZE'(1);
    endfunction

    state_e state_q, state_d;

    logic [BANK_BITS-1:0]  cap_bank_q;
    logic [ADDR_SIZE-1:0]  cap_addr_q;
    logic                  hit_q;
    logic [ENTRY_BITS-1:0] hit_idx_q;
    logic [ENTRY_BITS-1:0] scan_idx_q;
    logic                  max_found_q;
    logic [CNT_SIZE-1:0]   max_cnt_q;
    logic [ENTRY_BITS-1:0] max_idx_q;
    logic                  nrr_valid_q;
    logic [BANK_BITS-1:0]  nrr_bank_q;
    logic [ADDR_SIZE-1:0]  nrr_addr_q;
    logic [NUM_BANK-1:0]   alert_q;

    logic                 entry_valid_q [NUM_BANK][NUM_ENTRY];
    logic [ADDR_SIZE-1:0] entry_addr_q  [NUM_BANK][NUM_ENTRY];
    logic [CNT_SIZE-1:0]  entry_cnt_q   [NUM_BANK][NUM_ENTRY];
    logic [CNT_SIZE-1:0]  spcnt_q       [NUM_BANK];
    logic [CNT_SIZE-1:0]  raa_q         [NUM_BANK];

    logic                  bank_ok;
    logic [BANK_BITS-1:0]  bank_sel;
    logic                  lk_hit;
    logic [ENTRY_BITS-1:0] lk_idx;
    logic                  free_found;
    logic [ENTRY_BITS-1:0] free_idx;
    logic                  match_found;
    logic [ENTRY_BITS-1:0] match_idx;
    logic                  cur_valid;
    logic [CNT_SIZE-1:0]   cur_cnt;
    logic                  take;
    logic                  fin_found;
    logic [CNT_SIZE-1:0]   fin_cnt;
    logic [ENTRY_BITS-1:0] fin_idx;
    logic                  scan_last;
    logic                  accept;

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;
    assign nrr_valid = nrr_valid_q;
    assign nrr_bank  = nrr_bank_q;
    assign nrr_addr  = nrr_addr_q;
    assign alert     = alert_q;

    // Out-of-range banks run the normal timing but are steered away from all writes.
    assign bank_ok  = (32'(cap_bank_q) < NUM_BANK);
    assign bank_sel = bank_ok ? cap_bank_q : '0;

    always_comb begin
        lk_hit      = 1'b0;
        lk_idx      = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned e = 0; e < NUM_ENTRY; e++) begin
            if (!lk_hit && entry_valid_q[bank_sel][e] &&
                entry_addr_q[bank_sel][e] == cap_addr_q) begin
                lk_hit = 1'b1;
                lk_idx = ENTRY_BITS'(e);
            end
            if (!free_found && !entry_valid_q[bank_sel][e]) begin
                free_found = 1'b1;
                free_idx   = ENTRY_BITS'(e);
            end
            if (!match_found && entry_valid_q[bank_sel][e] &&
                entry_cnt_q[bank_sel][e] == spcnt_q[bank_sel]) begin
                match_found = 1'b1;
                match_idx   = ENTRY_BITS'(e);
            end
        end
    end

    // Running max over the scan; strict compare keeps the lowest index on ties.
    always_comb begin
        cur_valid = entry_valid_q[bank_sel][scan_idx_q];
        cur_cnt   = entry_cnt_q[bank_sel][scan_idx_q];
        take      = cur_valid && (!max_found_q || cur_cnt > max_cnt_q);
        fin_found = max_found_q || take;
        fin_cnt   = take ? cur_cnt : max_cnt_q;
        fin_idx   = take ? scan_idx_q : max_idx_q;
        scan_last = (scan_idx_q == ENTRY_BITS'(NUM_ENTRY - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = cmd_type ? StScan : StLookup;
            StLookup: state_d = StUpdate;
            StUpdate: state_d = StIdle;
            StScan:   if (scan_last) state_d = StEmit;
            StEmit:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cap_bank_q  <= '0;
            cap_addr_q  <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            scan_idx_q  <= '0;
            max_found_q <= 1'b0;
            max_cnt_q   <= '0;
            max_idx_q   <= '0;
            nrr_valid_q <= 1'b0;
            nrr_bank_q  <= '0;
            nrr_addr_q  <= '0;
            alert_q     <= '0;
        end else begin
            state_q     <= state_d;
            nrr_valid_q <= 1'b0;
            nrr_bank_q  <= '0;
            nrr_addr_q  <= '0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        cap_bank_q  <= cmd_bank;
                        cap_addr_q  <= cmd_addr;
                        scan_idx_q  <= '0;
                        max_found_q <= 1'b0;
                        max_cnt_q   <= '0;
                        max_idx_q   <= '0;
                    end
                end
                StLookup: begin
                    hit_q     <= lk_hit;
                    hit_idx_q <= lk_idx;
                end
                StScan: begin
                    scan_idx_q  <= scan_idx_q + ENTRY_BITS'(1);
                    max_found_q <= fin_found;
                    max_cnt_q   <= fin_cnt;
                    max_idx_q   <= fin_idx;
                    // Register the NRR so it is presented during the EMIT cycle.
                    if (scan_last && bank_ok && fin_found && fin_cnt >= RfmTh) begin
                        nrr_valid_q <= 1'b1;
                        nrr_bank_q  <= cap_bank_q;
                        nrr_addr_q  <= entry_addr_q[bank_sel][fin_idx];
                    end
                end
                default: ;
            endcase
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                alert_q[b] <= (raa_q[b] >= RaaMax);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                spcnt_q[b] <= '0;
                raa_q[b]   <= '0;
                for (int unsigned e = 0; e < NUM_ENTRY; e++) begin
                    entry_valid_q[b][e] <= 1'b0;
                    entry_addr_q[b][e]  <= '0;
                    entry_cnt_q[b][e]   <= '0;
                end
            end
        end else if (bank_ok) begin
            if (state_q == StUpdate) begin
                if (hit_q) begin
                    entry_cnt_q[bank_sel][hit_idx_q] <= sat_inc(entry_cnt_q[bank_sel][hit_idx_q]);
                end else if (free_found) begin
                    entry_valid_q[bank_sel][free_idx] <= 1'b1;
                    entry_addr_q[bank_sel][free_idx]  <= cap_addr_q;
                    entry_cnt_q[bank_sel][free_idx]   <= sat_inc(spcnt_q[bank_sel]);
                end else if (match_found) begin
                    entry_addr_q[bank_sel][match_idx] <= cap_addr_q;
                    entry_cnt_q[bank_sel][match_idx]  <= sat_inc(spcnt_q[bank_sel]);
                end else begin
                    spcnt_q[bank_sel] <= sat_inc(spcnt_q[bank_sel]);
                end
                raa_q[bank_sel] <= sat_inc(raa_q[bank_sel]);
            end else if (state_q == StEmit) begin
                if (nrr_valid_q) begin
                    entry_cnt_q[bank_sel][max_idx_q] <= spcnt_q[bank_sel];
                end
                raa_q[bank_sel] <= (raa_q[bank_sel] >= RaaImt) ? raa_q[bank_sel] - RaaImt : '0;
            end
        end
    end

endmodule

// File: doc/rfm_tracker_mb.md
Name: rfm_tracker_mb

Overview:
- Multi-bank successor of the single-bank RFM tracker.
- Keeps a per-bank Misra-Gries table (row address, activation count, valid bit) plus a per-bank spillover counter.
- Keeps a per-bank rolling accumulated ACT (RAA) counter with an alert output.
- Sits between the memory-controller command stream and the near-row-refresh (NRR) issue logic; one command is processed at a time through a valid/ready handshake.

Parameters:
- NUM_BANK, 4, number of tracked banks.
- BANK_BITS, 2, log2(NUM_BANK), rounded up.
- NUM_ENTRY, 16, table entries per bank.
- ENTRY_BITS, 4, log2(NUM_ENTRY).
- ADDR_SIZE, 18, row address width.
- CNT_SIZE, 16, width of entry count, spillover count and RAA count.
- RFM_TH, 20, minimum max-entry count required to issue an NRR.
- RAA_IMT, 32, RAA decrement applied per RFM.
- RAA_MAX, 128, RAA alert level.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_type  in  1  0 = ACT, 1 = RFM.
- cmd_bank  in  BANK_BITS  target bank.
- cmd_addr  in  ADDR_SIZE  row address (ACT only).
- nrr_valid  out  1  one-cycle NRR request.
- nrr_bank  out  BANK_BITS  bank of the NRR.
- nrr_addr  out  ADDR_SIZE  row of the NRR.
- alert  out  NUM_BANK  per-bank RAA alert, registered.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst. All state updates on posedge clk.
- Reset values:
  - cmd_ready=1; nrr_valid=0; nrr_bank=0; nrr_addr=0; alert=0.
  - All entries: valid=0, count=0, addr=0.
  - All spillover counts = 0; all RAA counts = 0.
  - FSM = IDLE.
  - Reset mid-operation aborts any ACT or RFM in flight; no partial write survives.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = (state == IDLE); it is combinational from the state register.
  - cmd_type, cmd_bank and cmd_addr are captured on accept.
- FSM states: IDLE, LOOKUP, UPDATE, SCAN, EMIT.
  - IDLE -> LOOKUP on an accepted ACT.
  - IDLE -> SCAN on an accepted RFM.
  - LOOKUP -> UPDATE -> IDLE.
  - SCAN stays for NUM_ENTRY cycles (index 0..NUM_ENTRY-1), then -> EMIT -> IDLE.
  - ACT occupancy: cmd_ready low for 2 cycles after accept.
  - RFM occupancy: cmd_ready low for NUM_ENTRY+1 cycles after accept.
- ACT, LOOKUP cycle: compare the captured addr against all valid entries of the bank and register hit/index. Addresses are unique within a bank.
- ACT, UPDATE cycle, priority order:
  - Hit: count+1, saturating at 2^CNT_SIZE-1.
  - Miss with an invalid entry: write the lowest-index invalid entry with valid=1, addr, count=spcnt+1.
  - Miss with an entry whose count == spcnt: write the lowest such index with the new addr, count=spcnt+1.
  - Otherwise: spcnt+1, saturating.
  - In every case RAA[bank]+1, saturating at 2^CNT_SIZE-1.
- RFM, SCAN:
  - Sequentially track the max count among valid entries of the bank.
  - Strict greater-than comparison, so the lowest index wins on ties.
- RFM, EMIT:
  - If a valid max exists and max >= RFM_TH: nrr_valid=1 for exactly this cycle, with nrr_bank/nrr_addr set; that entry's count is set to spcnt(bank).
  - Else nrr_valid stays 0 and no table change.
  - In both cases RAA[bank] = max(RAA - RAA_IMT, 0).
  - nrr_bank/nrr_addr return to 0 when nrr_valid=0.
- Alert:
  - alert[b] is registered; it is 1 the cycle after RAA[b] >= RAA_MAX, and 0 the cycle after RAA[b] < RAA_MAX.
  - ACTs to an alerting bank are still accepted and counted.
- Out-of-range bank (cmd_bank >= NUM_BANK): the command is accepted and completes normal state timing, but no table, spcnt or RAA change and no NRR.
- Commands on other banks never alter a bank's state.

Test Plan:
- Reset, then ACT bank1 addr 0x00ABC -> cmd_ready low 2 cycles; bank1 entry0 valid with count 1; bank0/2/3 untouched.
- 20 ACTs bank2 addr 0x00100, then RFM bank2 -> nrr_valid pulses at cycle NUM_ENTRY+1 (17) after accept, with nrr_bank=2, nrr_addr=0x00100; entry count returns to 0; RAA[2]=0 (20-32 floors at 0).
- Fill bank0 with 16 distinct addrs (count 1 each), then ACT a 17th addr -> spcnt=1, no replacement. Then ACT an 18th addr -> the lowest entry with count==1 (entry0) is replaced, with count=2.
- 5 ACTs bank3 addr X, then RFM bank3 -> no nrr_valid (5 < 20); table unchanged; RAA[3]=0.
- 128 ACTs bank0 -> alert[0]=1 one cycle after the 128th UPDATE. RFM bank0 -> RAA=96 and alert[0] deasserts.
- Assert rst during the SCAN of an RFM -> next cycle cmd_ready=1, nrr_valid never pulses, all tables and counters cleared.
